micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/ucode_pkg.sv | 26 ++
 rtl/ustack.sv | 44 ++++
 rtl/micro_sequencer.sv | 119 +++++++++++
 tb/tb_micro_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// rtl/ucode_pkg.sv - shared micro-sequencer encodings.
package ucode_pkg;

  typedef enum logic [3:0] {
    SEQ_NEXT  = 4'd0,
    SEQ_MAP   = 4'd1,
    SEQ_FETCH = 4'd2,
    SEQ_JUMP  = 4'd3,
    SEQ_CJUMP = 4'd4,
    SEQ_CALL  = 4'd5,
    SEQ_RET   = 4'd6,
    SEQ_WAIT  = 4'd7
  } seq_e;

  typedef enum logic [2:0] {
    COND_NEVER  = 3'd0,
    COND_LT     = 3'd1,
    COND_EQ     = 3'd2,
    COND_LE     = 3'd3,
    COND_GT     = 3'd4,
    COND_NE     = 3'd5,
    COND_GE     = 3'd6,
    COND_ALWAYS = 3'd7
  } cond_e;

endpackage

// File: rtl/ustack.sv
// rtl/ustack.sv - micro-return stack; pointer resets, entry contents do not.
module ustack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic                     full,
  output logic                     empty,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_idx, top_idx;

  assign wr_idx  = count_q[AW-1:0];
  assign top_idx = wr_idx - 1'b1;
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign top     = mem_q[top_idx];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !full)       count_d = count_q + 1'b1;
    else if (pop && !empty)  count_d = count_q - 1'b1;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  always_ff @(negedge clk) begin
    if (push && !full) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - falling-edge micro-sequencer with return stack.
module micro_sequencer
  import ucode_pkg::*;
#(
  parameter int CAR_W = 8,
  parameter int OPC_W = 4,
  parameter int IW    = 16,
  parameter int UW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IW-1:0]            instr,
  input  logic [1:0]               flg,
  input  logic [UW-1:0]            uword,
  input  logic                     mem_ready,
  input  logic                     hold,
  output logic [CAR_W-1:0]         car,
  output logic [3:0]               uop,
  output logic                     stalled,
  output logic                     stack_err,
  output logic [$clog2(DEPTH):0]   sp
);
  if (UW < CAR_W + 8) begin : g_bad_uw
    $error("micro_sequencer: UW must be >= CAR_W+8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("micro_sequencer: DEPTH must be a power of two >= 2");
  end

  function automatic logic cond_eval(input logic [2:0] c, input logic eq, input logic lt);
    case (c)
      COND_NEVER:  return 1'b0;
      COND_LT:     return lt;
      COND_EQ:     return eq;
      COND_LE:     return lt | eq;
      COND_GT:     return ~lt & ~eq;
      COND_NE:     return ~eq;
      COND_GE:     return ~lt;
      default:     return 1'b1;
    endcase
  endfunction

  logic [CAR_W-1:0] car_q, car_d, car_inc, target, stk_top;
  logic             err_q, err_d, push, pop, stk_full, stk_empty;
  logic [3:0]       seq;
  logic [OPC_W-1:0] opcode;
  logic             unused_ok;

  assign seq       = uword[3:0];
  assign target    = uword[CAR_W+3:4];
  assign opcode    = instr[IW-1 -: OPC_W];
  assign car_inc   = car_q + 1'b1;
  assign unused_ok = ^{instr, uword};

  assign stalled   = hold || (seq == SEQ_WAIT && !mem_ready);
  assign uop       = stalled ? 4'h0 : uword[UW-1 -: 4];
  assign car       = car_q;
  assign stack_err = err_q;

  ustack #(.DEPTH(DEPTH), .W(CAR_W)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (car_inc),
    .full  (stk_full),
    .empty (stk_empty),
    .top   (stk_top),
    .count (sp)
  );

  always_comb begin
    car_d = car_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    // hold outranks every mode, including stack traffic
    if (!hold) begin
      case (seq)
        SEQ_MAP:   car_d = CAR_W'(opcode) << (CAR_W - OPC_W);
        SEQ_FETCH: car_d = '0;
        SEQ_JUMP:  car_d = target;
        SEQ_CJUMP: car_d = cond_eval(instr[11:9], flg[1], flg[0]) ? target : car_inc;
        SEQ_CALL: begin
          if (stk_full) begin
            err_d = 1'b1;
            car_d = '0;
          end else begin
            push  = 1'b1;
            car_d = target;
          end
        end
        SEQ_RET: begin
          if (stk_empty) begin
            err_d = 1'b1;
            car_d = '0;
          end else begin
            pop   = 1'b1;
            car_d = stk_top;
          end
        end
        SEQ_WAIT:  if (mem_ready) car_d = car_inc;
        default:   car_d = car_inc;
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      car_q <= '0;
      err_q <= 1'b0;
    end else begin
      car_q <= car_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - self-checking bench for micro_sequencer.
module tb_micro_sequencer;
  localparam int DEPTH = 4;

  logic        clk, rst, mem_ready, hold;
  logic [15:0] instr, uword;
  logic [1:0]  flg;
  logic [7:0]  car;
  logic [3:0]  uop;
  logic        stalled, stack_err;
  logic [2:0]  sp;

  int checks = 0;
  int failures = 0;

  int car_m;
  int stack_m[$];
  bit err_m;

  micro_sequencer #(.CAR_W(8), .OPC_W(4), .IW(16), .UW(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .instr(instr), .flg(flg), .uword(uword),
    .mem_ready(mem_ready), .hold(hold), .car(car), .uop(uop),
    .stalled(stalled), .stack_err(stack_err), .sp(sp)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic [1:0]  f;
    logic [3:0]  s;
    logic [7:0]  t;
    logic        m;
    logic        h;
    logic [7:0]  ecar;
    logic [2:0]  esp;
    logic        estl;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cond_m(input logic [2:0] c, input logic [1:0] f);
    bit eq = f[1];
    bit lt = f[0];
    case (c)
      0: return 0;
      1: return lt;
      2: return eq;
      3: return lt || eq;
      4: return !lt && !eq;
      5: return !eq;
      6: return !lt;
      default: return 1;
    endcase
  endfunction

  task automatic step(input logic [15:0] ins, input logic [1:0] f, input logic [3:0] s,
                      input logic [7:0] t, input logic [3:0] u, input logic m, input logic h);
    bit exp_stl;
    int nxt;
    instr = ins; flg = f; uword = {u, t, s}; mem_ready = m; hold = h;
    #1;
    exp_stl = h || (s == 4'd7 && !m);
    chk("stalled", stalled, exp_stl);
    chk("uop", uop, exp_stl ? 0 : u);
    if (!h) begin
      nxt = (car_m + 1) % 256;
      case (s)
        1: car_m = ins[15:12] * 16;
        2: car_m = 0;
        3: car_m = t;
        4: car_m = cond_m(ins[11:9], f) ? t : nxt;
        5: if (stack_m.size() == DEPTH) begin err_m = 1; car_m = 0; end
           else begin stack_m.push_back(nxt); car_m = t; end
        6: if (stack_m.size() == 0) begin err_m = 1; car_m = 0; end
           else car_m = stack_m.pop_back();
        7: if (m) car_m = nxt;
        default: car_m = nxt;
      endcase
    end
    @(negedge clk); #1;
    chk("car", car, car_m);
    chk("sp", sp, stack_m.size());
    chk("stack_err", stack_err, err_m);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    car_m = 0; err_m = 0; stack_m.delete();
    chk("rst_car", car, 0);
    chk("rst_sp", sp, 0);
    chk("rst_err", stack_err, 0);
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  localparam logic [15:0] C2 = 16'h0400;

  initial begin
    rst = 1'b1; instr = '0; flg = '0; uword = '0; mem_ready = 1'b0; hold = 1'b0;
    car_m = 0; err_m = 0;
    @(negedge clk); #1;
    chk("reset_car", car, 0);
    chk("reset_sp", sp, 0);
    chk("reset_err", stack_err, 0);
    chk("reset_stalled", stalled, 0);
    rst = 1'b0;

    tbl.push_back('{16'h0000, 2'b00, 4'd3, 8'h10, 1'b0, 1'b0, 8'h10, 3'd0, 1'b0});
    tbl.push_back('{C2,       2'b10, 4'd4, 8'h40, 1'b0, 1'b0, 8'h40, 3'd0, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd3, 8'h10, 1'b0, 1'b0, 8'h10, 3'd0, 1'b0});
    tbl.push_back('{C2,       2'b00, 4'd4, 8'h40, 1'b0, 1'b0, 8'h11, 3'd0, 1'b0});
    tbl.push_back('{16'hA000, 2'b00, 4'd1, 8'h00, 1'b0, 1'b0, 8'hA0, 3'd0, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd3, 8'h10, 1'b0, 1'b0, 8'h10, 3'd0, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd5, 8'h80, 1'b0, 1'b0, 8'h80, 3'd1, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd5, 8'hC0, 1'b0, 1'b0, 8'hC0, 3'd2, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd6, 8'h00, 1'b0, 1'b0, 8'h81, 3'd1, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd6, 8'h00, 1'b0, 1'b0, 8'h11, 3'd0, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd3, 8'h30, 1'b0, 1'b0, 8'h30, 3'd0, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd7, 8'h00, 1'b0, 1'b0, 8'h30, 3'd0, 1'b1});
    tbl.push_back('{16'h0000, 2'b00, 4'd7, 8'h00, 1'b0, 1'b0, 8'h30, 3'd0, 1'b1});
    tbl.push_back('{16'h0000, 2'b00, 4'd7, 8'h00, 1'b0, 1'b0, 8'h30, 3'd0, 1'b1});
    tbl.push_back('{16'h0000, 2'b00, 4'd7, 8'h00, 1'b1, 1'b0, 8'h31, 3'd0, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd5, 8'h55, 1'b1, 1'b1, 8'h31, 3'd0, 1'b1});
    tbl.push_back('{16'h0000, 2'b00, 4'd5, 8'h55, 1'b1, 1'b0, 8'h55, 3'd1, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd6, 8'h00, 1'b1, 1'b1, 8'h55, 3'd1, 1'b1});
    tbl.push_back('{16'h0000, 2'b00, 4'd2, 8'h77, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd9, 8'h77, 1'b0, 1'b0, 8'h01, 3'd1, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd3, 8'hFF, 1'b0, 1'b0, 8'hFF, 3'd1, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd3, 8'hFF, 1'b0, 1'b0, 8'hFF, 3'd1, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd5, 8'h20, 1'b0, 1'b0, 8'h20, 3'd2, 1'b0});
    tbl.push_back('{16'h0000, 2'b00, 4'd6, 8'h00, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0});

    foreach (tbl[i]) begin
      step(tbl[i].ins, tbl[i].f, tbl[i].s, tbl[i].t, 4'hC, tbl[i].m, tbl[i].h);
      chk($sformatf("tbl%0d_car", i), car, tbl[i].ecar);
      chk($sformatf("tbl%0d_sp", i), sp, tbl[i].esp);
      chk($sformatf("tbl%0d_stalled", i), stalled, tbl[i].estl);
    end

    // overflow: fifth CALL on a full stack
    do_reset();
    for (int i = 1; i <= 4; i++) step(16'h0, 2'b00, 4'd5, 8'(i * 16), 4'h1, 1'b0, 1'b0);
    chk("ovf_sp_full", sp, 4);
    step(16'h0, 2'b00, 4'd5, 8'h50, 4'h1, 1'b0, 1'b0);
    chk("ovf_err", stack_err, 1);
    chk("ovf_car", car, 0);
    chk("ovf_sp", sp, 4);
    step(16'h0, 2'b00, 4'd3, 8'h12, 4'h1, 1'b0, 1'b0);
    chk("err_sticky", stack_err, 1);

    // underflow, then reset in the middle of a WAIT
    do_reset();
    step(16'h0, 2'b00, 4'd6, 8'h00, 4'h2, 1'b0, 1'b0);
    chk("unf_err", stack_err, 1);
    chk("unf_car", car, 0);
    step(16'h0, 2'b00, 4'd5, 8'h25, 4'h2, 1'b0, 1'b0);
    step(16'h0, 2'b00, 4'd7, 8'h00, 4'h2, 1'b0, 1'b0);
    chk("wait_car25", car, 8'h25);
    chk("wait_sp1", sp, 1);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      if (i % 64 == 63) do_reset();
      step(16'($urandom), 2'($urandom), 4'($urandom_range(0, 15)), 8'($urandom),
           4'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
